// File: rtl/ct_lsu_dirty_walk_pkg.sv
// Shared types and dirty-array layout for the dcache dirty walker.
// Bits 6:2 of a dirty-array entry are owned by other agents and never written here.
package ct_lsu_dirty_walk_pkg;

   localparam int unsigned DIRTY_W = 7;
   localparam int unsigned DIRTY_WAY_BIT [2] = '{0, 1};

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WB,
      CLR,
      NEXT
   } walk_state_e;

   function automatic logic [1:0] way_bits(input logic [DIRTY_W-1:0] d);
      return {d[DIRTY_WAY_BIT[1]], d[DIRTY_WAY_BIT[0]]};
   endfunction

   // Active-low per-bit write enable covering only the given ways.
   function automatic logic [DIRTY_W-1:0] wen_mask(input logic [1:0] ways);
      logic [DIRTY_W-1:0] m;
      m = '1;
      for (int w = 0; w < 2; w++) begin
         if (ways[w]) m[DIRTY_WAY_BIT[w]] = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/ct_lsu_dirty_walk_wbsel.sv
// Per-index 2-way bookkeeping: pending writebacks, written-back ways, store-race keep bits,
// and way0-first selection of the next writeback.
module ct_lsu_dirty_walk_wbsel
   import ct_lsu_dirty_walk_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       load,
   input  logic [1:0] load_pend,
   input  logic       set_hit,
   input  logic       set_way,
   input  logic       accept,
   output logic       sel_way,
   output logic       pend_left,
   output logic [1:0] clr_ways
);

   logic [1:0] pend;
   logic [1:0] wbd;
   logic [1:0] keep;
   logic [1:0] acc_oh;
   logic [1:0] set_oh;

   assign sel_way   = ~pend[0];
   assign acc_oh    = accept ? (sel_way ? 2'b10 : 2'b01) : 2'b00;
   assign set_oh    = set_hit ? (set_way ? 2'b10 : 2'b01) : 2'b00;
   assign pend_left = |(pend & ~acc_oh);
   // Same-cycle store sets are folded in so a set racing the clear grant is honoured.
   assign clr_ways  = wbd & ~(keep | set_oh);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= 2'b00;
         wbd  <= 2'b00;
         keep <= 2'b00;
      end else if (start) begin
         pend <= 2'b00;
         wbd  <= 2'b00;
         keep <= 2'b00;
      end else begin
         pend <= load ? load_pend : (pend & ~acc_oh);
         wbd  <= wbd | acc_oh;
         keep <= keep | set_oh;
      end
   end

endmodule

// File: rtl/ct_lsu_dcache_dirty_walker.sv
// Sweeps the dcache dirty array, issues writebacks for dirty ways and optionally clears them.
// Optional writeback counter output enabled by CT_LSU_DIRTY_WALK_PERF_EN.
module ct_lsu_dcache_dirty_walker
   import ct_lsu_dirty_walk_pkg::*;
#(
   parameter int unsigned IDX_W    = 9,
   parameter int unsigned LAST_IDX = 511
) (
   input  logic               forever_cpuclk,
   input  logic               cpurst,
   input  logic               walk_req,
   input  logic               walk_clr,
   output logic               walk_busy,
   output logic               walk_done,
   output logic               walk_arb_req,
   input  logic               walk_arb_grnt,
   output logic               dirty_gateclk_en,
   output logic               dirty_sel_b,
   output logic               dirty_gwen_b,
   output logic [IDX_W-1:0]   dirty_idx,
   output logic [DIRTY_W-1:0] dirty_din,
   output logic [DIRTY_W-1:0] dirty_wen_b,
   input  logic [DIRTY_W-1:0] dirty_dout,
   input  logic               dirty_set_vld,
   input  logic [IDX_W-1:0]   dirty_set_idx,
   input  logic               dirty_set_way,
   output logic               wb_req_vld,
   output logic [IDX_W-1:0]   wb_req_idx,
   output logic               wb_req_way,
   input  logic               wb_req_rdy
`ifdef CT_LSU_DIRTY_WALK_PERF_EN
   ,
   output logic [IDX_W+1:0]   walk_wb_cnt
`endif
);

   walk_state_e        state;
   logic [IDX_W-1:0]   cur_idx;
   logic               clr_mode;
   logic [DIRTY_W-1:0] dirty_q;
   logic               busy_q;
   logic               done_q;
   logic               sel_way;
   logic               pend_left;
   logic [1:0]         clr_ways;
   logic               last_idx;
   logic               wb_hs;
   logic               set_hit;
   logic               clr_need;
   logic               rd_go;
   logic               clr_go;
   logic               unused_dirty_q;

   assign last_idx = (cur_idx == IDX_W'(LAST_IDX));
   assign wb_hs    = (state == WB) && wb_req_rdy;
   assign set_hit  = dirty_set_vld && (dirty_set_idx == cur_idx) &&
                     ((state == CAP) || (state == WB) || (state == CLR));
   // No arbitration is requested when every written-back way was re-dirtied by a store.
   assign clr_need = (state == CLR) && (|clr_ways);
   assign rd_go    = (state == RD) && walk_arb_grnt;
   assign clr_go   = clr_need && walk_arb_grnt;

   assign walk_busy        = busy_q;
   assign walk_done        = done_q;
   assign walk_arb_req     = (state == RD) || clr_need;
   assign dirty_sel_b      = ~(rd_go | clr_go);
   assign dirty_gateclk_en = rd_go | clr_go;
   assign dirty_gwen_b     = ~clr_go;
   assign dirty_idx        = (rd_go | clr_go) ? cur_idx : '0;
   assign dirty_din        = '0;
   assign dirty_wen_b      = clr_go ? wen_mask(clr_ways) : '1;
   assign wb_req_vld       = (state == WB);
   assign wb_req_idx       = cur_idx;
   assign wb_req_way       = sel_way;
   assign unused_dirty_q   = ^dirty_q;

   ct_lsu_dirty_walk_wbsel u_wbsel (
      .clk       (forever_cpuclk),
      .rst       (cpurst),
      .start     (state == RD),
      .load      (state == CAP),
      .load_pend (way_bits(dirty_dout)),
      .set_hit   (set_hit),
      .set_way   (dirty_set_way),
      .accept    (wb_hs),
      .sel_way   (sel_way),
      .pend_left (pend_left),
      .clr_ways  (clr_ways)
   );

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state    <= IDLE;
         cur_idx  <= '0;
         clr_mode <= 1'b0;
         dirty_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (walk_req) begin
                  clr_mode <= walk_clr;
                  cur_idx  <= '0;
                  busy_q   <= 1'b1;
                  state    <= RD;
               end
            end
            RD: begin
               if (walk_arb_grnt) state <= CAP;
            end
            CAP: begin
               dirty_q <= dirty_dout;
               // Clean indices skip the writeback phase entirely.
               state   <= (|way_bits(dirty_dout)) ? WB : NEXT;
            end
            WB: begin
               if (wb_hs && !pend_left) state <= clr_mode ? CLR : NEXT;
            end
            CLR: begin
               if (!clr_need || walk_arb_grnt) state <= NEXT;
            end
            NEXT: begin
               if (last_idx) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cur_idx <= cur_idx + IDX_W'(1);
                  state   <= RD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CT_LSU_DIRTY_WALK_PERF_EN
   logic [IDX_W+1:0] wb_cnt;

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         wb_cnt <= '0;
      end else if ((state == IDLE) && walk_req) begin
         wb_cnt <= '0;
      end else if (wb_hs && (wb_cnt != '1)) begin
         wb_cnt <= wb_cnt + 1'b1;
      end
   end

   assign walk_wb_cnt = wb_cnt;
`endif

endmodule

// File: tb/tb_ct_lsu_dcache_dirty_walker.sv
// Directed bench for the dirty walker with a 4-entry dirty-array model (LAST_IDX=3).
module tb_ct_lsu_dcache_dirty_walker;

   localparam int unsigned IDX_W = 9;
   localparam int unsigned LAST  = 3;

   logic             clk;
   logic             cpurst;
   logic             walk_req;
   logic             walk_clr;
   logic             walk_busy;
   logic             walk_done;
   logic             walk_arb_req;
   logic             walk_arb_grnt;
   logic             dirty_gateclk_en;
   logic             dirty_sel_b;
   logic             dirty_gwen_b;
   logic [IDX_W-1:0] dirty_idx;
   logic [6:0]       dirty_din;
   logic [6:0]       dirty_wen_b;
   logic [6:0]       dirty_dout;
   logic             dirty_set_vld;
   logic [IDX_W-1:0] dirty_set_idx;
   logic             dirty_set_way;
   logic             wb_req_vld;
   logic [IDX_W-1:0] wb_req_idx;
   logic             wb_req_way;
   logic             wb_req_rdy;

   ct_lsu_dcache_dirty_walker #(
      .IDX_W    (IDX_W),
      .LAST_IDX (LAST)
   ) dut (
      .forever_cpuclk   (clk),
      .cpurst           (cpurst),
      .walk_req         (walk_req),
      .walk_clr         (walk_clr),
      .walk_busy        (walk_busy),
      .walk_done        (walk_done),
      .walk_arb_req     (walk_arb_req),
      .walk_arb_grnt    (walk_arb_grnt),
      .dirty_gateclk_en (dirty_gateclk_en),
      .dirty_sel_b      (dirty_sel_b),
      .dirty_gwen_b     (dirty_gwen_b),
      .dirty_idx        (dirty_idx),
      .dirty_din        (dirty_din),
      .dirty_wen_b      (dirty_wen_b),
      .dirty_dout       (dirty_dout),
      .dirty_set_vld    (dirty_set_vld),
      .dirty_set_idx    (dirty_set_idx),
      .dirty_set_way    (dirty_set_way),
      .wb_req_vld       (wb_req_vld),
      .wb_req_idx       (wb_req_idx),
      .wb_req_way       (wb_req_way),
      .wb_req_rdy       (wb_req_rdy)
   );

   always #5 clk = ~clk;

   logic [6:0] tab [4];

   always @(posedge clk) begin
      if (!dirty_sel_b && dirty_gwen_b) dirty_dout <= tab[dirty_idx[1:0]];
   end

   int               n_rd = 0;
   int               n_wr = 0;
   int               n_wb = 0;
   logic [IDX_W-1:0] rd_idx [256];
   logic [IDX_W-1:0] wr_idx [256];
   logic [6:0]       wr_wen [256];
   logic [6:0]       wr_din [256];
   logic [IDX_W-1:0] wb_idx [256];
   logic             wb_way [256];

   always @(negedge clk) begin
      if (!dirty_sel_b && dirty_gwen_b && n_rd < 256) begin
         rd_idx[n_rd] = dirty_idx;
         n_rd++;
      end
      if (!dirty_sel_b && !dirty_gwen_b && n_wr < 256) begin
         wr_idx[n_wr] = dirty_idx;
         wr_wen[n_wr] = dirty_wen_b;
         wr_din[n_wr] = dirty_din;
         n_wr++;
      end
      if (wb_req_vld && wb_req_rdy && n_wb < 256) begin
         wb_idx[n_wb] = wb_req_idx;
         wb_way[n_wb] = wb_req_way;
         n_wb++;
      end
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_walk(input logic clr);
      walk_clr = clr;
      walk_req = 1'b1;
      @(posedge clk);
      #1 walk_req = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cyc);
      bit found;
      found = 0;
      cyc   = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1 cyc++;
         if (walk_done) found = 1;
      end
      check_eq({tag, "_done_seen"}, 32'(found), 32'd1);
   endtask

   task automatic wait_vld(input string tag);
      bit found;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk);
         #1;
         if (wb_req_vld) found = 1;
      end
      check_eq({tag, "_vld_seen"}, 32'(found), 32'd1);
   endtask

   int cyc;
   int b_rd;
   int b_wr;
   int b_wb;

   initial begin
      clk           = 1'b0;
      cpurst        = 1'b1;
      walk_req      = 1'b0;
      walk_clr      = 1'b0;
      walk_arb_grnt = 1'b1;
      dirty_set_vld = 1'b0;
      dirty_set_idx = '0;
      dirty_set_way = 1'b0;
      wb_req_rdy    = 1'b1;
      dirty_dout    = '0;
      for (int i = 0; i < 4; i++) tab[i] = 7'h00;
      repeat (3) @(posedge clk);
      #1 cpurst = 1'b0;
      #1;

      check_eq("rst_busy", 32'(walk_busy), 32'd0);
      check_eq("rst_done", 32'(walk_done), 32'd0);
      check_eq("rst_arb_req", 32'(walk_arb_req), 32'd0);
      check_eq("rst_sel_b", 32'(dirty_sel_b), 32'd1);
      check_eq("rst_gwen_b", 32'(dirty_gwen_b), 32'd1);
      check_eq("rst_wen_b", 32'(dirty_wen_b), 32'h7f);
      check_eq("rst_idx", 32'(dirty_idx), 32'd0);
      check_eq("rst_wb_vld", 32'(wb_req_vld), 32'd0);
      check_eq("rst_gateclk", 32'(dirty_gateclk_en), 32'd0);

      // All-clean sweep: 3 cycles per index, done 12 cycles after the request.
      b_rd = n_rd; b_wr = n_wr; b_wb = n_wb;
      start_walk(1'b1);
      check_eq("clean_busy", 32'(walk_busy), 32'd1);
      wait_done("clean", cyc);
      check_eq("clean_latency", 32'(cyc), 32'd12);
      check_eq("clean_reads", 32'(n_rd - b_rd), 32'd4);
      for (int i = 0; i < 4; i++) check_eq("clean_rd_idx", 32'(rd_idx[b_rd + i]), 32'(i));
      check_eq("clean_wbs", 32'(n_wb - b_wb), 32'd0);
      check_eq("clean_writes", 32'(n_wr - b_wr), 32'd0);
      @(posedge clk);
      #1;
      check_eq("clean_done_pulse", 32'(walk_done), 32'd0);
      check_eq("clean_idle_busy", 32'(walk_busy), 32'd0);

      // Both ways dirty at idx 2, clear mode.
      tab[2] = 7'b0000011;
      b_rd = n_rd; b_wr = n_wr; b_wb = n_wb;
      start_walk(1'b1);
      wait_done("dirty_clr", cyc);
      check_eq("dc_wbs", 32'(n_wb - b_wb), 32'd2);
      check_eq("dc_wb0_idx", 32'(wb_idx[b_wb]), 32'd2);
      check_eq("dc_wb0_way", 32'(wb_way[b_wb]), 32'd0);
      check_eq("dc_wb1_idx", 32'(wb_idx[b_wb + 1]), 32'd2);
      check_eq("dc_wb1_way", 32'(wb_way[b_wb + 1]), 32'd1);
      check_eq("dc_writes", 32'(n_wr - b_wr), 32'd1);
      check_eq("dc_wr_idx", 32'(wr_idx[b_wr]), 32'd2);
      check_eq("dc_wr_wen", 32'(wr_wen[b_wr]), 32'(7'b1111100));
      check_eq("dc_wr_din", 32'(wr_din[b_wr]), 32'd0);

      // Same data, writeback only.
      b_rd = n_rd; b_wr = n_wr; b_wb = n_wb;
      start_walk(1'b0);
      wait_done("dirty_noclr", cyc);
      check_eq("dn_wbs", 32'(n_wb - b_wb), 32'd2);
      check_eq("dn_writes", 32'(n_wr - b_wr), 32'd0);

      // Writeback buffer stalls for 5 cycles on a way0-only line.
      tab[2]     = 7'b0000001;
      wb_req_rdy = 1'b0;
      b_rd = n_rd; b_wr = n_wr; b_wb = n_wb;
      start_walk(1'b1);
      wait_vld("stall");
      for (int i = 0; i < 5; i++) begin
         check_eq("stall_vld", 32'(wb_req_vld), 32'd1);
         check_eq("stall_idx", 32'(wb_req_idx), 32'd2);
         check_eq("stall_way", 32'(wb_req_way), 32'd0);
         @(posedge clk);
         #1;
      end
      wb_req_rdy = 1'b1;
      wait_done("stall", cyc);
      check_eq("stall_wbs", 32'(n_wb - b_wb), 32'd1);
      check_eq("stall_writes", 32'(n_wr - b_wr), 32'd1);
      check_eq("stall_wr_wen", 32'(wr_wen[b_wr]), 32'(7'b1111110));

      // Store sets way1 of idx 2 during writeback: way1 must stay dirty.
      tab[2]     = 7'b0000011;
      wb_req_rdy = 1'b0;
      b_rd = n_rd; b_wr = n_wr; b_wb = n_wb;
      start_walk(1'b1);
      wait_vld("race");
      dirty_set_vld = 1'b1;
      dirty_set_idx = 9'd2;
      dirty_set_way = 1'b1;
      @(posedge clk);
      #1 dirty_set_vld = 1'b0;
      wb_req_rdy = 1'b1;
      wait_done("race", cyc);
      check_eq("race_wbs", 32'(n_wb - b_wb), 32'd2);
      check_eq("race_writes", 32'(n_wr - b_wr), 32'd1);
      check_eq("race_wr_idx", 32'(wr_idx[b_wr]), 32'd2);
      check_eq("race_wr_wen", 32'(wr_wen[b_wr]), 32'(7'b1111110));

      // Reset while a writeback is outstanding, then restart from idx 0.
      wb_req_rdy = 1'b0;
      b_wr = n_wr;
      start_walk(1'b1);
      wait_vld("rst_mid");
      cpurst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rstm_busy", 32'(walk_busy), 32'd0);
      check_eq("rstm_wb_vld", 32'(wb_req_vld), 32'd0);
      check_eq("rstm_arb_req", 32'(walk_arb_req), 32'd0);
      check_eq("rstm_sel_b", 32'(dirty_sel_b), 32'd1);
      cpurst     = 1'b0;
      wb_req_rdy = 1'b1;
      tab[2]     = 7'b0000000;
      b_rd = n_rd; b_wb = n_wb;
      start_walk(1'b1);
      wait_done("restart", cyc);
      check_eq("restart_reads", 32'(n_rd - b_rd), 32'd4);
      check_eq("restart_rd0_idx", 32'(rd_idx[b_rd]), 32'd0);
      check_eq("restart_wbs", 32'(n_wb - b_wb), 32'd0);
      check_eq("restart_no_write", 32'(n_wr - b_wr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
